gray_code_counter: RTL and testbench

Parametrised up/down counter that keeps a binary count and a registered Gray-code image of it. This is the sequential successor to the team's fixed 3-bit binary-to-Gray converter. It generalises width, adds count direction, parallel load, and wrap/saturate modes, and produces a terminal-count pulse. It feeds Gray-coded pointers and positions to clock-domain-crossing logic and encoder interfaces, and exposes the matching binary value to local logic.

---
 rtl/gray_code_counter_if.sv | 22 ++
 rtl/gray_code_counter.sv | 67 ++++++
 tb/tb_gray_code_counter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_code_counter_if.sv
// Control and status bundle for gray_code_counter: step/load controls in, binary/Gray count out.
interface gray_code_counter_if #(
  parameter int unsigned WIDTH = 3
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             tc;

  modport master (
    output en, up, load, load_bin,
    input  bin, gray, tc
  );

  modport slave (
    input  en, up, load, load_bin,
    output bin, gray, tc
  );
endinterface

// File: rtl/gray_code_counter.sv
// Up/down binary counter with a registered Gray image and a terminal-count pulse.
// WRAP selects wrap-around or saturation at 0 and MAX.
module gray_code_counter #(
  parameter int unsigned      WIDTH = 3,
  parameter bit               WRAP  = 1'b1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input logic                clk,
  input logic                rst_n,
  gray_code_counter_if.slave cnt
);

  localparam logic [WIDTH-1:0] MaxVal   = '1;
  localparam logic [WIDTH-1:0] InitGray = INIT ^ (INIT >> 1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;

  // tc flags any enabled step attempted at a limit, whether it wraps or is blocked.
  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (cnt.load) begin
      bin_d = cnt.load_bin;
    end else if (cnt.en) begin
      if (cnt.up) begin
        if (bin_q != MaxVal) begin
          bin_d = bin_q + 1'b1;
        end else begin
          tc_d = 1'b1;
          if (WRAP) begin
            bin_d = '0;
          end
        end
      end else begin
        if (bin_q != '0) begin
          bin_d = bin_q - 1'b1;
        end else begin
          tc_d = 1'b1;
          if (WRAP) begin
            bin_d = MaxVal;
          end
        end
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // Gray is registered from the same next state so bin and gray never skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= INIT;
      gray_q <= InitGray;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign cnt.bin  = bin_q;
  assign cnt.gray = gray_q;
  assign cnt.tc   = tc_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Scoreboard bench for gray_code_counter: three configurations driven side by side.
module tb_gray_code_counter;

  typedef struct {
    int id;
    int bin;
    int gray;
    int tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_code_counter_if #(.WIDTH(3)) if_a ();
  gray_code_counter_if #(.WIDTH(3)) if_b ();
  gray_code_counter_if #(.WIDTH(4)) if_c ();

  gray_code_counter #(.WIDTH(3), .WRAP(1'b1), .INIT(3'd0)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (if_a)
  );
  gray_code_counter #(.WIDTH(3), .WRAP(1'b1), .INIT(3'd5)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (if_b)
  );
  gray_code_counter #(.WIDTH(4), .WRAP(1'b0), .INIT(4'd0)) u_dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (if_c)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  int m_bin[3];
  int m_tc[3];
  int m_w[3]    = '{3, 3, 4};
  int m_wrap[3] = '{1, 1, 0};
  int m_init[3] = '{0, 5, 0};

  logic [2:0] gray_seq[9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                              3'b101, 3'b100, 3'b000, 3'b001};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_bin[i] = m_init[i];
      m_tc[i]  = 0;
    end
  endtask

  task automatic model_step(input int id, input logic load, input logic en, input logic up,
                            input int lb);
    int   maxv;
    exp_t e;
    maxv     = (1 << m_w[id]) - 1;
    m_tc[id] = 0;
    if (load) begin
      m_bin[id] = lb;
    end else if (en) begin
      if (up) begin
        if (m_bin[id] == maxv) begin
          m_tc[id] = 1;
          if (m_wrap[id] != 0) m_bin[id] = 0;
        end else begin
          m_bin[id] = m_bin[id] + 1;
        end
      end else begin
        if (m_bin[id] == 0) begin
          m_tc[id] = 1;
          if (m_wrap[id] != 0) m_bin[id] = maxv;
        end else begin
          m_bin[id] = m_bin[id] - 1;
        end
      end
    end
    e.id   = id;
    e.bin  = m_bin[id];
    e.gray = m_bin[id] ^ (m_bin[id] >> 1);
    e.tc   = m_tc[id];
    sb_q.push_back(e);
  endtask

  task automatic drv_a(input logic load, input logic en, input logic up, input int lb);
    if_a.load = load; if_a.en = en; if_a.up = up; if_a.load_bin = lb[2:0];
  endtask
  task automatic drv_b(input logic load, input logic en, input logic up, input int lb);
    if_b.load = load; if_b.en = en; if_b.up = up; if_b.load_bin = lb[2:0];
  endtask
  task automatic drv_c(input logic load, input logic en, input logic up, input int lb);
    if_c.load = load; if_c.en = en; if_c.up = up; if_c.load_bin = lb[3:0];
  endtask

  // Predict from the inputs now on the buses, clock once, then score every DUT.
  task automatic step();
    exp_t        e;
    logic [31:0] ob, og, ot;
    model_step(0, if_a.load, if_a.en, if_a.up, int'(if_a.load_bin));
    model_step(1, if_b.load, if_b.en, if_b.up, int'(if_b.load_bin));
    model_step(2, if_c.load, if_c.en, if_c.up, int'(if_c.load_bin));
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.id)
        0:       begin ob = 32'(if_a.bin); og = 32'(if_a.gray); ot = 32'(if_a.tc); end
        1:       begin ob = 32'(if_b.bin); og = 32'(if_b.gray); ot = 32'(if_b.tc); end
        default: begin ob = 32'(if_c.bin); og = 32'(if_c.gray); ot = 32'(if_c.tc); end
      endcase
      check_val($sformatf("sb%0d_bin", e.id), ob, e.bin);
      check_val($sformatf("sb%0d_gray", e.id), og, e.gray);
      check_val($sformatf("sb%0d_tc", e.id), ot, e.tc);
    end
  endtask

  initial begin
    logic [2:0] prev;
    drv_a(0, 0, 0, 0);
    drv_b(0, 0, 0, 0);
    drv_c(0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    check_val("rst_a_bin", if_a.bin, 0);
    check_val("rst_a_gray", if_a.gray, 0);
    check_val("rst_a_tc", if_a.tc, 0);
    check_val("rst_b_bin", if_b.bin, 5);
    check_val("rst_b_gray", if_b.gray, 7);
    check_val("rst_c_bin", if_c.bin, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step();
    check_val("idle_a_bin", if_a.bin, 0);

    // Wrap-up sequence on A while C counts freely.
    drv_a(0, 1, 1, 0);
    drv_c(0, 1, 1, 0);
    for (int i = 0; i < 9; i++) begin
      prev = if_a.gray;
      step();
      check_val($sformatf("a_up_gray%0d", i), if_a.gray, gray_seq[i]);
      check_val($sformatf("a_up_tc%0d", i), if_a.tc, (i == 7) ? 1 : 0);
      check_val($sformatf("a_up_onebit%0d", i), $countones(if_a.gray ^ prev), 1);
    end
    drv_c(0, 0, 0, 0);

    // Count down through zero.
    drv_a(1, 0, 0, 0);
    step();
    drv_a(0, 1, 0, 0);
    step();
    check_val("a_dn_bin0", if_a.bin, 7);
    check_val("a_dn_gray0", if_a.gray, 3'b100);
    check_val("a_dn_tc0", if_a.tc, 1);
    step();
    check_val("a_dn_bin1", if_a.bin, 6);
    check_val("a_dn_gray1", if_a.gray, 3'b101);
    check_val("a_dn_tc1", if_a.tc, 0);

    // Load beats enable; loading a limit raises no tc.
    drv_a(1, 0, 0, 2);
    step();
    drv_a(1, 1, 1, 5);
    step();
    check_val("ld_bin", if_a.bin, 5);
    check_val("ld_gray", if_a.gray, 3'b111);
    check_val("ld_tc", if_a.tc, 0);
    drv_a(1, 1, 1, 7);
    step();
    check_val("ld_max_bin", if_a.bin, 7);
    check_val("ld_max_tc", if_a.tc, 0);
    drv_a(0, 1, 1, 0);
    step();
    check_val("wrap_bin", if_a.bin, 0);
    check_val("wrap_tc", if_a.tc, 1);

    // Saturation on C (from 9), B counting down meanwhile.
    drv_a(0, 0, 0, 0);
    drv_b(0, 1, 0, 0);
    drv_c(0, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_val($sformatf("c_climb_tc%0d", i), if_c.tc, 0);
    end
    check_val("c_top_bin", if_c.bin, 15);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("c_sat_bin%0d", i), if_c.bin, 15);
      check_val($sformatf("c_sat_gray%0d", i), if_c.gray, 4'b1000);
      check_val($sformatf("c_sat_tc%0d", i), if_c.tc, 1);
    end
    drv_c(0, 1, 0, 0);
    step();
    check_val("c_rev_bin", if_c.bin, 14);
    check_val("c_rev_tc", if_c.tc, 0);
    drv_b(0, 0, 0, 0);

    // Asynchronous reset between edges, with a tc pulse in flight on C.
    drv_a(1, 0, 0, 6);
    drv_c(1, 0, 0, 15);
    step();
    drv_a(0, 0, 0, 0);
    drv_c(0, 1, 1, 0);
    step();
    check_val("pre_rst_a_bin", if_a.bin, 6);
    check_val("pre_rst_c_tc", if_c.tc, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_a_bin", if_a.bin, 0);
    check_val("mid_rst_a_gray", if_a.gray, 0);
    check_val("mid_rst_a_tc", if_a.tc, 0);
    check_val("mid_rst_b_bin", if_b.bin, 5);
    check_val("mid_rst_c_bin", if_c.bin, 0);
    check_val("mid_rst_c_tc", if_c.tc, 0);
    model_reset();
    drv_a(0, 1, 1, 0);
    drv_c(0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_val("held_rst_a_bin", if_a.bin, 0);
    rst_n = 1'b1;
    step();
    check_val("resume_a_bin", if_a.bin, 1);
    check_val("resume_a_gray", if_a.gray, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish before 20000");
    $fatal(1);
  end

endmodule
